// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage: radix-2 shift-add
// multiply and restoring divide, one bit per cycle, stalling the pipeline until done.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ALL_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
    return ALL_ZERO - v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
    return {(2*XLEN){1'b0}} - v;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic              is_div_s;
  logic              sign_a_s;
  logic              sign_b_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_next_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_diff_s;
  logic [2*XLEN-1:0] div_next_s;
  logic [2*XLEN-1:0] iter_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   final_s;

  assign is_div_s   = funct3_i[2];
  assign sign_a_s   = a_i[XLEN-1] & ((funct3_i == F_MULH) | (funct3_i == F_MULHSU) |
                                     (funct3_i == F_DIV)  | (funct3_i == F_REM));
  assign sign_b_s   = b_i[XLEN-1] & ((funct3_i == F_MULH) | (funct3_i == F_DIV) |
                                     (funct3_i == F_REM));
  assign mag_a_s    = sign_a_s ? neg_w(a_i) : a_i;
  assign mag_b_s    = sign_b_s ? neg_w(b_i) : b_i;
  assign div_zero_s = (b_i == ALL_ZERO);
  assign div_ovf_s  = ((funct3_i == F_DIV) | (funct3_i == F_REM)) &
                      (a_i == INT_MIN) & (b_i == ALL_ONES);

  // Multiply keeps the multiplier in the low half and shifts the partial product right.
  assign mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                      (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};

  // Divide keeps {remainder, dividend/quotient} and shifts left, restoring on borrow.
  assign div_shift_s = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff_s  = div_shift_s - {1'b0, opnd_q};
  assign div_next_s  = div_diff_s[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                        : {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign iter_s = op_q[2] ? div_next_s : mul_next_s;
  assign prod_s = qneg_q ? neg_dw(iter_s) : iter_s;

  // Sign correction and selection of the architectural result from the last iteration.
  always_comb begin
    final_s = ALL_ZERO;
    case (op_q)
      F_MUL:                   final_s = prod_s[XLEN-1:0];
      F_MULH, F_MULHSU,
      F_MULHU:                 final_s = prod_s[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:           final_s = qneg_q ? neg_w(iter_s[XLEN-1:0]) : iter_s[XLEN-1:0];
      F_REM, F_REMU:           final_s = rneg_q ? neg_w(iter_s[2*XLEN-1:XLEN])
                                                : iter_s[2*XLEN-1:XLEN];
      default:                 final_s = ALL_ZERO;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (valid_i) begin
          op_d = funct3_i;
          if (is_div_s && div_zero_s) begin
            result_d = funct3_i[1] ? a_i : ALL_ONES;
            state_d  = S_DONE;
            done_d   = 1'b1;
          end else if (div_ovf_s) begin
            result_d = funct3_i[1] ? ALL_ZERO : INT_MIN;
            state_d  = S_DONE;
            done_d   = 1'b1;
          end else begin
            opnd_d  = is_div_s ? mag_b_s : mag_a_s;
            acc_d   = {ALL_ZERO, (is_div_s ? mag_a_s : mag_b_s)};
            qneg_d  = sign_a_s ^ sign_b_s;
            rneg_d  = sign_a_s;
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = iter_s;
          if (cnt_q == CNT_LAST) begin
            result_d = final_s;
            state_d  = S_DONE;
            done_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      op_q     <= 3'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= ALL_ZERO;
      acc_q    <= {(2*XLEN){1'b0}};
      result_q <= ALL_ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // The stall is gated by reset so a held valid_i cannot leak through while in reset.
  assign stall_o  = rst_n & valid_i & (state_q != S_DONE) & ~flush_i;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
